div: RTL and testbench

- Multi-cycle 32-bit divider, signed or unsigned, serving the execute stage for DIV/DIVU.
- The execute stage is the initiator: it raises `start_i` with the operands and stalls the pipeline. This block is the responder: it returns `{remainder, quotient}` with `ready_o` after a fixed iteration count.
- The result is destined for the HI/LO write path.

---
 rtl/div.sv | 120 ++++++++++++
 tb/tb_div.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// +-----------------------------------------------------------------------+
// | div: multi-cycle 32-bit signed/unsigned radix-2 divider for DIV/DIVU   |
// | Revision: 1.0                                                           |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [64:0] dvd_q;
  logic [31:0] divisor_q;
  logic        neg_quot_q;
  logic        neg_rem_q;

  logic [31:0] op1_abs;
  logic [31:0] op2_abs;
  logic [32:0] diff;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    op1_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    op2_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    // Trial subtraction; bit 32 set means the partial remainder is below the divisor.
    diff    = {1'b0, dvd_q[63:32]} - {1'b0, divisor_q};
    quot    = neg_quot_q ? (~dvd_q[31:0] + 32'd1) : dvd_q[31:0];
    rem     = neg_rem_q ? (~dvd_q[64:33] + 32'd1) : dvd_q[64:33];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FREE;
      cnt_q      <= 6'd0;
      dvd_q      <= 65'd0;
      divisor_q  <= 32'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_o   <= 64'd0;
      ready_o    <= 1'b0;
    end else begin
      case (state_q)
        S_FREE: begin
          ready_o  <= 1'b0;
          result_o <= 64'd0;
          if (start_i && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state_q <= S_BYZERO;
            end else begin
              state_q    <= S_ON;
              cnt_q      <= 6'd0;
              dvd_q      <= {32'd0, op1_abs, 1'b0};
              divisor_q  <= op2_abs;
              neg_quot_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
              neg_rem_q  <= signed_div_i & opdata1_i[31];
            end
          end
        end

        S_BYZERO: begin
          state_q  <= S_END;
          result_o <= 64'd0;
          ready_o  <= 1'b1;
        end

        S_ON: begin
          if (annul_i) begin
            state_q <= S_FREE;
            cnt_q   <= 6'd0;
          end else if (cnt_q < 6'd32) begin
            if (diff[32]) begin
              dvd_q <= dvd_q << 1;
            end else begin
              dvd_q <= {diff[31:0], dvd_q[31:0], 1'b1};
            end
            cnt_q <= cnt_q + 6'd1;
          end else begin
            result_o <= {rem, quot};
            ready_o  <= 1'b1;
            cnt_q    <= 6'd0;
            state_q  <= S_END;
          end
        end

        S_END: begin
          if (!start_i) begin
            state_q  <= S_FREE;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
          end
        end

        default: begin
          state_q <= S_FREE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div.sv
// +-----------------------------------------------------------------------+
// | tb_div: directed scoreboard bench for the div block                    |
// | Revision: 1.0                                                           |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   cyc        = 0;
  int   sample_cyc = 0;
  logic prev_ready = 1'b0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising ready_o is matched against the oldest outstanding request.
  always @(negedge clk) begin
    if (ready_o && !prev_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready: ready_o=1 result=%h with no request outstanding", result_o);
      end else begin
        cur = exp_q.pop_front();
        check64("result", result_o, cur.res);
        check64("latency", 64'(cyc - sample_cyc), 64'(cur.lat));
      end
    end
    prev_ready = ready_o;
  end

  // Called at a negedge; returns 1ns after the sampling edge.
  task automatic start_req(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] res, input int lat);
    exp_t e;
    e.res = res;
    e.lat = lat;
    exp_q.push_back(e);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    #1;
    sample_cyc = cyc;
  endtask

  task automatic wait_ready();
    bit seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ready_o) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: ready_o=0 after 60 cycles, expected 1");
    end
  endtask

  task automatic release_req(input int hold, input logic [63:0] res);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check64("hold_ready", {63'd0, ready_o}, 64'd1);
      check64("hold_result", result_o, res);
    end
    start_i = 1'b0;
    @(negedge clk);
    check64("drop_ready", {63'd0, ready_o}, 64'd0);
    check64("drop_result", result_o, 64'd0);
  endtask

  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] res, input int lat);
    start_req(s, a, b, res, lat);
    wait_ready();
    release_req(0, res);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    bit rose = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ready_o) rose = 1'b1;
    end
    check64(name, {63'd0, rose}, 64'd0);
  endtask

  // Aborts an unsigned 100/7 with annul_i sampled while cnt == iter.
  task automatic annul_at(input int iter);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (iter) @(posedge clk);
    #1;
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    expect_quiet("annul_no_ready", 40);
  endtask

  initial begin
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #1;
    check64("reset_ready", {63'd0, ready_o}, 64'd0);
    check64("reset_result", result_o, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check64("idle_ready", {63'd0, ready_o}, 64'd0);
    check64("idle_result", result_o, 64'd0);

    start_req(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
    wait_ready();
    release_req(2, 64'h00000002_0000000E);

    do_div(1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33);
    do_div(1'b0, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC, 33);
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
    do_div(1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF, 33);
    do_div(1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    do_div(1'b1, 32'hFFFFFF9C, 32'h00000007, 64'hFFFFFFFE_FFFFFFF2, 33);
    do_div(1'b1, 32'h00003039, 32'h00000000, 64'h0, 1);
    do_div(1'b0, 32'hFFFFFFFF, 32'h00000000, 64'h0, 1);

    annul_at(10);
    do_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);
    annul_at(32);

    // start and annul together in FREE must not launch a divide
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    annul_i      = 1'b1;
    repeat (3) @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;
    expect_quiet("start_annul_no_ready", 40);

    // asynchronous reset during iteration 20, request held and restarted
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd10;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #4;
    rst = 1'b0;
    #1;
    check64("async_rst_ready", {63'd0, ready_o}, 64'd0);
    check64("async_rst_result", result_o, 64'd0);
    #2;
    rst = 1'b1;
    start_req(1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, 33);
    wait_ready();
    release_req(0, 64'h00000000_00000064);

    // asynchronous reset while a result is being presented
    start_req(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
    wait_ready();
    #2;
    rst = 1'b0;
    #1;
    check64("end_rst_ready", {63'd0, ready_o}, 64'd0);
    check64("end_rst_result", result_o, 64'd0);
    start_i = 1'b0;
    #2;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    check64("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
